// File: rtl/comparator_4bit_if.sv
// Operand and result bundle for the 4-bit unsigned magnitude comparator.
// The master side supplies the operands; the slave side (the comparator)
// returns the combinational and registered compare results.
interface comparator_4bit_if;
  logic [3:0] a;
  logic [3:0] b;
  logic       eq;
  logic       gt;
  logic       lt;
  logic [3:0] diff;
  logic       eq_q;
  logic       gt_q;
  logic       lt_q;
  logic       changed;

  modport master (
    output a, b,
    input  eq, gt, lt, diff, eq_q, gt_q, lt_q, changed
  );

  modport slave (
    input  a, b,
    output eq, gt, lt, diff, eq_q, gt_q, lt_q, changed
  );
endinterface

// File: rtl/comparator_4bit.sv
// 4-bit unsigned magnitude comparator.
// eq/gt/lt/diff are purely combinational and independent of clock and reset.
// eq_q/gt_q/lt_q hold the compare code captured at each rising edge, and
// changed flags, for one cycle, an edge whose code differs from the previous
// edge's code. The first edge after reset only primes the history, so no
// transition is ever reported out of reset.
module comparator_4bit (
  input  logic            clk,
  input  logic            rst_n,
  comparator_4bit_if.slave bus
);

  logic       eq_s;
  logic       gt_s;
  logic       lt_s;
  logic [3:0] diff_s;
  logic [2:0] code_s;
  logic [2:0] code_r;
  logic       changed_r;
  logic       primed_r;

  // MSB-first scan: the highest differing bit decides gt or lt.
  always_comb begin
    eq_s = 1'b1;
    gt_s = 1'b0;
    lt_s = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (eq_s && (bus.a[i] != bus.b[i])) begin
        eq_s = 1'b0;
        gt_s = bus.a[i];
        lt_s = bus.b[i];
      end else begin
        eq_s = eq_s;
      end
    end
  end

  // Magnitude of the difference: subtract the smaller operand from the larger.
  always_comb begin
    diff_s = 4'd0;
    if (gt_s) begin
      diff_s = bus.a - bus.b;
    end else begin
      diff_s = bus.b - bus.a;
    end
  end

  assign code_s = {eq_s, gt_s, lt_s};

  // Capture the compare code each edge; changed only after history is primed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_r    <= 3'b000;
      changed_r <= 1'b0;
      primed_r  <= 1'b0;
    end else begin
      code_r    <= code_s;
      changed_r <= primed_r && (code_s != code_r);
      primed_r  <= 1'b1;
    end
  end

  assign bus.eq      = eq_s;
  assign bus.gt      = gt_s;
  assign bus.lt      = lt_s;
  assign bus.diff    = diff_s;
  assign bus.eq_q    = code_r[2];
  assign bus.gt_q    = code_r[1];
  assign bus.lt_q    = code_r[0];
  assign bus.changed = changed_r;

endmodule

// File: tb/tb_comparator_4bit.sv
// Self-checking bench for comparator_4bit: directed vectors, exhaustive
// combinational sweep, randomized registered traffic and reset pulses,
// all against an arithmetic reference model.
module tb_comparator_4bit;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   hist[$];   // compare codes (0 eq, 1 gt, 2 lt) sampled since reset

  comparator_4bit_if bus_i ();

  comparator_4bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int code_of(input int a, input int b);
    if (a == b) return 0;
    else if (a > b) return 1;
    else return 2;
  endfunction

  // Reference history: reset empties it, each edge appends the current code.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist.delete();
    else hist.push_back(code_of(int'(bus_i.a), int'(bus_i.b)));
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (a=%0d b=%0d t=%0t)",
               tag, got, exp, bus_i.a, bus_i.b, $time);
    end
  endtask

  task automatic check_comb();
    int a, b, d, c;
    a = int'(bus_i.a);
    b = int'(bus_i.b);
    c = code_of(a, b);
    d = (a >= b) ? (a - b) : (b - a);
    check_val("eq",   32'(bus_i.eq),   32'(c == 0));
    check_val("gt",   32'(bus_i.gt),   32'(c == 1));
    check_val("lt",   32'(bus_i.lt),   32'(c == 2));
    check_val("diff", 32'(bus_i.diff), 32'(d));
    check_val("onehot", 32'(int'(bus_i.eq) + int'(bus_i.gt) + int'(bus_i.lt)), 32'd1);
  endtask

  task automatic check_reg();
    int n, c, ch;
    n  = hist.size();
    c  = (n > 0) ? hist[n-1] : -1;
    ch = (n >= 2) ? int'(hist[n-1] != hist[n-2]) : 0;
    check_val("eq_q",    32'(bus_i.eq_q),    32'(c == 0));
    check_val("gt_q",    32'(bus_i.gt_q),    32'(c == 1));
    check_val("lt_q",    32'(bus_i.lt_q),    32'(c == 2));
    check_val("changed", 32'(bus_i.changed), 32'(ch));
  endtask

  // Drive operands away from the rising edge.
  task automatic drive(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    bus_i.a = a;
    bus_i.b = b;
  endtask

  // Advance one rising edge and check the registered outputs just after it.
  task automatic tick_check();
    @(posedge clk);
    #1;
    check_reg();
    check_comb();
  endtask

  initial begin
    logic [3:0] va [5];
    logic [3:0] vb [5];
    checks   = 0;
    failures = 0;
    va[0] = 4'b0101; vb[0] = 4'b0101;
    va[1] = 4'b1010; vb[1] = 4'b0110;
    va[2] = 4'b0011; vb[2] = 4'b0111;
    va[3] = 4'b0000; vb[3] = 4'b1111;
    va[4] = 4'b1111; vb[4] = 4'b0000;

    rst_n   = 1'b0;
    bus_i.a = 4'd0;
    bus_i.b = 4'd0;
    #2;
    check_reg();

    // Directed vectors under reset: combinational outputs must still be live.
    for (int i = 0; i < 5; i++) begin
      bus_i.a = va[i];
      bus_i.b = vb[i];
      #1;
      check_comb();
      check_reg();
    end
    check_val("dir_diff_1111", 32'(bus_i.diff), 32'd15);

    // Release reset away from the edge; first edge must not report changed.
    drive(4'd1, 4'd2);
    rst_n = 1'b1;
    tick_check();
    tick_check();
    check_val("hold_lt_q", 32'(bus_i.lt_q), 32'd1);
    drive(4'd2, 4'd2);
    #1;
    check_val("pre_edge_lt_q", 32'(bus_i.lt_q), 32'd1);
    check_val("pre_edge_eq", 32'(bus_i.eq), 32'd1);
    tick_check();
    check_val("xfer_eq_q", 32'(bus_i.eq_q), 32'd1);
    check_val("xfer_changed", 32'(bus_i.changed), 32'd1);
    tick_check();
    check_val("xfer_changed_drop", 32'(bus_i.changed), 32'd0);

    // Exhaustive combinational sweep; registers tracked alongside.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        drive(4'(a), 4'(b));
        #1;
        check_comb();
        check_reg();
      end
    end

    // Randomized traffic with frequent holds to exercise both changed states.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(2) != 0) begin
        drive(4'($urandom_range(15)), 4'($urandom_range(15)));
      end else begin
        @(negedge clk);
      end
      tick_check();
    end

    // Mid-operation reset pulse between edges.
    drive(4'd9, 4'd3);
    tick_check();
    tick_check();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reg();
    check_val("rst_gt_q", 32'(bus_i.gt_q), 32'd0);
    check_comb();
    #1;
    rst_n = 1'b1;
    tick_check();
    check_val("post_rst_changed", 32'(bus_i.changed), 32'd0);
    check_val("post_rst_gt_q", 32'(bus_i.gt_q), 32'd1);
    drive(4'd3, 4'd9);
    tick_check();
    check_val("post_rst_change", 32'(bus_i.changed), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/comparator_4bit.md
COMPARATOR_4BIT -- requirements
Module: comparator_4bit

Interface
REQ-001 Parameters: none; operand width fixed at 4 bits, unsigned.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for the registered outputs.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 a  input  4  operand A, unsigned.
REQ-006 b  input  4  operand B, unsigned.
REQ-007 eq  output  1  combinational: a == b.
REQ-008 gt  output  1  combinational: a > b.
REQ-009 lt  output  1  combinational: a < b.
REQ-010 eq_q  output  1  eq registered on clk.
REQ-011 gt_q  output  1  gt registered on clk.
REQ-012 lt_q  output  1  lt registered on clk.
REQ-013 diff  output  4  combinational magnitude |a - b|.
REQ-014 changed  output  1  registered; 1 when the {eq,gt,lt} code sampled at this edge differs from the code sampled at the previous edge.

Function
REQ-015 eq, gt and lt shall be purely combinational from a and b, with zero clock latency, and shall not depend on clk or rst_n.
REQ-016 Exactly one of eq, gt and lt shall be 1 for every input pair (one-hot); no X or Z output for known inputs.
REQ-017 Comparison shall be unsigned magnitude over bits [3:0]; MSB priority: the first differing bit from bit 3 down decides gt or lt.
REQ-018 diff shall equal a-b when a>=b and b-a otherwise; diff=0 exactly when eq=1; maximum 15 (0 vs 15).
REQ-019 eq_q, gt_q and lt_q shall capture eq, gt and lt on each rising clk edge; latency 1 cycle; they remain one-hot after the first edge out of reset.
REQ-020 changed shall compare the newly captured code with the previously held eq_q, gt_q and lt_q at the same edge; it shall be 1 for exactly one cycle per transition.
REQ-021 Inputs changing between edges shall affect only the combinational outputs until the next edge.

Reset
REQ-022 rst_n=0 shall immediately, without waiting for a clock edge, force eq_q=0, gt_q=0, lt_q=0 and changed=0.
REQ-023 Reset shall not affect eq, gt, lt or diff.
REQ-024 On the first edge after rst_n deasserts, the registers shall load the current code and changed shall be 0; no transition is reported out of reset.
REQ-025 Reset asserted mid-operation shall clear all registered outputs asynchronously; the outputs shall resume per REQ-024.

Verification
REQ-026 a=0101, b=0101 -> eq=1 gt=0 lt=0 diff=0 within 10 ns, no clock required.
REQ-027 a=1010, b=0110 -> eq=0 gt=1 lt=0 diff=0100; a=0011, b=0111 -> lt=1 diff=0100.
REQ-028 Corners: a=0000, b=1111 -> lt=1 diff=1111; a=1111, b=0000 -> gt=1 diff=1111.
REQ-029 Exhaustive sweep of all 256 (a,b) pairs -> outputs one-hot and matching an unsigned reference model; diff matches the absolute difference.
REQ-030 Registered path: hold a=1,b=2 for two edges, then a=2,b=2 -> lt_q=1, then eq_q=1 one cycle after the input change; changed=1 for that single cycle only.
REQ-031 Pulse rst_n low between edges -> eq_q/gt_q/lt_q/changed=0 immediately while combinational outputs stay valid; first edge after release gives changed=0.
